// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-queue issue FSM states and
// the control characters used by newline expansion.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } txq_state_e;

    localparam logic [7:0] UART_LF = 8'h0A;
    localparam logic [7:0] UART_CR = 8'h0D;

endpackage

// File: rtl/uart_txq_fifo.sv
// Circular byte FIFO for the UART transmit queue with occupancy
// count, full/empty flags and a sticky overflow flag.
module uart_txq_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_i,
    input  logic                push,
    input  logic [7:0]          push_dat,
    input  logic                pop,
    output logic [7:0]          head_dat,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    // Fullness is judged before any same-cycle pop.
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge sys_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && full) begin
                ovf <= 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and issue sequencer feeding the UART transmitter.
// Define UART_TXQ_CRLF_EN to insert CR before each LF on the line.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_i,
    input  logic                txq_wr_i,
    input  logic [7:0]          txq_dat_i,
    output logic                txq_full_o,
    output logic                txq_empty_o,
    output logic [DEPTH_LOG2:0] txq_count_o,
    output logic                txq_ovf_o,
    output logic                txq_idle_o,
    output logic                uart_wr_o,
    output logic [7:0]          uart_dat_o,
    input  logic                uart_busy_i
);

    txq_state_e state;
    txq_state_e state_n;
    logic       pop;
    logic       load;
    logic [7:0] load_dat;
    logic [7:0] head_dat;

`ifdef UART_TXQ_CRLF_EN
    logic cr_pend;
    logic cr_pend_n;
`endif

    uart_txq_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .push      (txq_wr_i),
        .push_dat  (txq_dat_i),
        .pop       (pop),
        .head_dat  (head_dat),
        .full      (txq_full_o),
        .empty     (txq_empty_o),
        .count     (txq_count_o),
        .ovf       (txq_ovf_o)
    );

    assign txq_idle_o = txq_empty_o && (state == IDLE) && !uart_busy_i;

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        load      = 1'b0;
        load_dat  = head_dat;
        uart_wr_o = 1'b0;
`ifdef UART_TXQ_CRLF_EN
        cr_pend_n = cr_pend;
`endif
        unique case (state)
            IDLE: begin
                if (!txq_empty_o && !uart_busy_i) begin
                    load    = 1'b1;
                    state_n = ISSUE;
`ifdef UART_TXQ_CRLF_EN
                    // LF stays at the head until its CR has gone out.
                    if (head_dat == UART_LF && !cr_pend) begin
                        load_dat  = UART_CR;
                        cr_pend_n = 1'b1;
                    end else begin
                        pop       = 1'b1;
                        cr_pend_n = 1'b0;
                    end
`else
                    pop     = 1'b1;
`endif
                end
            end
            ISSUE: begin
                // Held until busy is seen; a lone pulse can be missed.
                uart_wr_o = 1'b1;
                if (uart_busy_i) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (!uart_busy_i) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state      <= IDLE;
            uart_dat_o <= 8'h00;
        end else begin
            state <= state_n;
            if (load) begin
                uart_dat_o <= load_dat;
            end
        end
    end

`ifdef UART_TXQ_CRLF_EN
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            cr_pend <= 1'b0;
        end else begin
            cr_pend <= cr_pend_n;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized self-checking bench for uart_tx_queue with a serial
// transmitter model, line decoder and expected-byte scoreboard.
module tb_uart_tx_queue;

    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txq_wr = 1'b0;
    logic [7:0] txq_dat = 8'h00;
    logic       hold = 1'b0;
    wire        full, empty, ovf, idle, uart_wr, uart_busy;
    wire  [7:0] uart_dat;
    wire  [4:0] count;

    int checks = 0;
    int failures = 0;

    // transmitter model state
    int         phase = 0;
    int         dly = 0;
    int         tcnt = 0;
    int         tx_delay = 0;
    int         accept_cnt = 0;
    logic       busy_r = 1'b0;
    logic [9:0] frame = 10'h3FF;
    wire        txd = (phase == 2) ? frame[tcnt / BC] : 1'b1;

    logic [7:0] exp_q[$];

    assign uart_busy = busy_r | hold;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH_LOG2(4)) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .txq_wr_i    (txq_wr),
        .txq_dat_i   (txq_dat),
        .txq_full_o  (full),
        .txq_empty_o (empty),
        .txq_count_o (count),
        .txq_ovf_o   (ovf),
        .txq_idle_o  (idle),
        .uart_wr_o   (uart_wr),
        .uart_dat_o  (uart_dat),
        .uart_busy_i (uart_busy)
    );

    // transmitter: latch on request, busy after tx_delay extra cycles,
    // then shift out start, 8 data bits LSB first, stop
    always @(posedge clk) begin
        if (rst) begin
            phase  <= 0;
            busy_r <= 1'b0;
            tcnt   <= 0;
            dly    <= 0;
        end else begin
            case (phase)
                0: if (uart_wr) begin
                    accept_cnt <= accept_cnt + 1;
                    frame <= {1'b1, uart_dat, 1'b0};
                    tcnt  <= 0;
                    if (tx_delay == 0) begin
                        busy_r <= 1'b1;
                        phase  <= 2;
                    end else begin
                        dly   <= tx_delay;
                        phase <= 1;
                    end
                end
                1: if (dly == 1) begin
                    busy_r <= 1'b1;
                    phase  <= 2;
                end else begin
                    dly <= dly - 1;
                end
                default: if (tcnt == 10 * BC - 1) begin
                    busy_r <= 1'b0;
                    phase  <= 0;
                end else begin
                    tcnt <= tcnt + 1;
                end
            endcase
        end
    end

    // serial decoder and scoreboard
    initial begin
        logic       ab, st, sp;
        logic [7:0] b, e;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                ab = 1'b0;
                repeat (BC / 2) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                st = txd;
                for (int k = 0; k < 8; k++) begin
                    repeat (BC) begin
                        @(negedge clk);
                        if (rst) ab = 1'b1;
                    end
                    b[k] = txd;
                end
                repeat (BC) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                end
                sp = txd;
                if (!ab) begin
                    checks++;
                    if (st !== 1'b0 || sp !== 1'b1) begin
                        failures++;
                        $display("FAIL frame: start=%b stop=%b, need 0/1", st, sp);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL serial: got %h, expected no byte", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e) begin
                            failures++;
                            $display("FAIL serial: got %h, expected %h", b, e);
                        end
                    end
                end
            end
        end
    end

    function automatic void exp_push(input logic [7:0] d);
`ifdef UART_TXQ_CRLF_EN
        if (d == 8'h0A) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(d);
    endfunction

    task automatic push_byte(input logic [7:0] d);
        txq_wr  = 1'b1;
        txq_dat = d;
        @(negedge clk);
        txq_wr  = 1'b0;
    endtask

    task automatic drain(output bit to);
        to = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (idle && phase == 0 && exp_q.size() == 0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] rnd_no_lf();
        logic [7:0] r;
        r = 8'($urandom_range(0, 255));
        if (r == 8'h0A) r = 8'h0B;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: cnt=%0d e=%b f=%b o=%b, need 0 1 0 0",
                     count, empty, full, ovf);
        end
        checks++;
        if (uart_wr !== 1'b0 || uart_dat !== 8'h00) begin
            failures++;
            $display("FAIL reset_uart: wr=%b dat=%h, need 0 00", uart_wr, uart_dat);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: idle=%b, need 1", idle);
        end
    endtask

    task automatic test_single();
        bit to;
        exp_push(8'h55);
        push_byte(8'h55);
        checks++;
        if (count !== 5'd1 || empty !== 1'b0 || uart_wr !== 1'b0) begin
            failures++;
            $display("FAIL single_n1: cnt=%0d e=%b wr=%b, need 1 0 0", count, empty, uart_wr);
        end
        @(negedge clk);
        checks++;
        if (uart_wr !== 1'b1 || uart_dat !== 8'h55) begin
            failures++;
            $display("FAIL single_n2: wr=%b dat=%h, need 1 55", uart_wr, uart_dat);
        end
        @(negedge clk);
        checks++;
        if (uart_wr !== 1'b1) begin
            failures++;
            $display("FAIL single_n3: wr=%b, need 1", uart_wr);
        end
        @(negedge clk);
        checks++;
        if (uart_wr !== 1'b0) begin
            failures++;
            $display("FAIL single_n4: wr=%b, need 0", uart_wr);
        end
        drain(to);
        checks++;
        if (to || idle !== 1'b1) begin
            failures++;
            $display("FAIL single_drain: timeout=%0d idle=%b left=%0d, need 0 1 0",
                     to, idle, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit         to;
        logic [7:0] d;
        int         n;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                d = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
                exp_push(d);
                push_byte(d);
            end
            drain(to);
            checks++;
            if (to || exp_q.size() != 0) begin
                failures++;
                $display("FAIL random_drain: timeout=%0d left=%0d, need 0 0", to, exp_q.size());
            end
            checks++;
            if (ovf !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
                failures++;
                $display("FAIL random_flags: o=%b cnt=%0d e=%b, need 0 0 1", ovf, count, empty);
            end
        end
    endtask

    task automatic test_crlf();
        bit to;
        exp_push(8'h41);
        push_byte(8'h41);
        exp_push(8'h0A);
        push_byte(8'h0A);
        exp_push(8'h42);
        push_byte(8'h42);
        drain(to);
        checks++;
        if (to || exp_q.size() != 0) begin
            failures++;
            $display("FAIL crlf_drain: timeout=%0d left=%0d, need 0 0", to, exp_q.size());
        end
    endtask

    task automatic test_busy_delay();
        bit to;
        bit stable;
        int n;
        int acc0;
        acc0 = accept_cnt;
        tx_delay = 3;
        exp_push(8'h3C);
        push_byte(8'h3C);
        for (int i = 0; i < 10 && !uart_wr; i++) @(negedge clk);
        n = 0;
        stable = 1'b1;
        while (uart_wr && n < 20) begin
            if (uart_dat !== 8'h3C) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 5 || !stable) begin
            failures++;
            $display("FAIL delay_hold: wr_cycles=%0d stable=%0d, need 5 1", n, stable);
        end
        drain(to);
        tx_delay = 0;
        checks++;
        if (to || accept_cnt - acc0 != 1) begin
            failures++;
            $display("FAIL delay_once: timeout=%0d accepted=%0d, need 0 1", to, accept_cnt - acc0);
        end
    endtask

    task automatic test_full_ovf();
        bit to;
        hold = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            exp_push(8'(i));
            push_byte(8'(i));
        end
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL full_fill: cnt=%0d f=%b o=%b, need 16 1 0", count, full, ovf);
        end
        push_byte(8'hFF);
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL full_ovf: cnt=%0d f=%b o=%b, need 16 1 1", count, full, ovf);
        end
        hold = 1'b0;
        @(negedge clk);
        checks++;
        if (count !== 5'd15 || full !== 1'b0) begin
            failures++;
            $display("FAIL full_pop: cnt=%0d f=%b, need 15 0", count, full);
        end
        drain(to);
        checks++;
        if (to || exp_q.size() != 0 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL full_drain: timeout=%0d left=%0d o=%b, need 0 0 1",
                     to, exp_q.size(), ovf);
        end
    endtask

    task automatic test_simul();
        bit         to;
        logic [7:0] d;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = rnd_no_lf();
            exp_push(d);
            push_byte(d);
        end
        for (int it = 0; it < 20; it++) begin
            if (it > 0) begin
                for (int i = 0; i < 20 && phase != 2; i++) @(negedge clk);
                for (int i = 0; i < 100 && phase != 0; i++) @(negedge clk);
                @(negedge clk);
                hold = 1'b0;
                @(negedge clk);
            end
            hold = 1'b0;
            d = rnd_no_lf();
            exp_push(d);
            push_byte(d);
            hold = 1'b1;
            checks++;
            if (count !== 5'd5) begin
                failures++;
                $display("FAIL simul_%0d: cnt=%0d, need 5", it, count);
            end
        end
        hold = 1'b0;
        drain(to);
        checks++;
        if (to || exp_q.size() != 0) begin
            failures++;
            $display("FAIL simul_drain: timeout=%0d left=%0d, need 0 0", to, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit wr_seen;
        int acc0;
        for (int i = 0; i < 4; i++) begin
            exp_push(8'hA1 + 8'(i));
            push_byte(8'hA1 + 8'(i));
        end
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (phase == 2 && tcnt >= 12) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        acc0 = accept_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (to || count !== 5'd0 || empty !== 1'b1 || uart_wr !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_q: timeout=%0d cnt=%0d e=%b wr=%b, need 0 0 1 0",
                     to, count, empty, uart_wr);
        end
        checks++;
        if (idle !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_state: idle=%b o=%b, need 1 0", idle, ovf);
        end
        rst = 1'b0;
        exp_q.delete();
        wr_seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (uart_wr) wr_seen = 1'b1;
        end
        checks++;
        if (wr_seen || accept_cnt != acc0) begin
            failures++;
            $display("FAIL rstmid_quiet: wr_seen=%0d new_accepts=%0d, need 0 0",
                     wr_seen, accept_cnt - acc0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_crlf();
        test_busy_delay();
        test_full_ovf();
        test_simul();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue and issue sequencer directly upstream of the UART transmitter. Host logic pushes bytes at any rate into a circular FIFO. The block drains the FIFO one byte at a time into the transmitter's `uart_wr`/`uart_dat`/`uart_busy` handshake, holding each request until the transmitter has accepted it. An optional newline-expansion stage inserts CR before each LF on the serial line.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries; legal range 1–8.
- `sys_clk_i` in 1: system clock, 50 MHz; the transmitter's clock.
- `sys_rst_i` in 1: synchronous, active-high reset.
- `txq_wr_i` in 1: push `txq_dat_i` this cycle.
- `txq_dat_i` in 8: byte to enqueue.
- `txq_full_o` out 1: FIFO holds 2^DEPTH_LOG2 entries.
- `txq_empty_o` out 1: FIFO holds 0 entries.
- `txq_count_o` out DEPTH_LOG2+1: current occupancy.
- `txq_ovf_o` out 1: sticky; set by a push while full.
- `txq_idle_o` out 1: FIFO empty, FSM in IDLE, `uart_busy_i` low.
- `uart_wr_o` out 1: request to the transmitter; drives its write input.
- `uart_dat_o` out 8: byte to the transmitter; stable while `uart_wr_o` is high.
- `uart_busy_i` in 1: transmitter busy.

## Operation
- Reset values:
  - `txq_count_o`=0, `txq_empty_o`=1, `txq_full_o`=0, `txq_ovf_o`=0.
  - `uart_wr_o`=0, `uart_dat_o`=0x00.
  - FSM in IDLE; read/write pointers 0; CR-pending flag 0.
- Push: accepted iff `txq_wr_i` and not full at the clock edge. The entry is written at `wr_ptr` and `wr_ptr` increments.
- Push while full: the byte is dropped and `txq_ovf_o` is set. It clears only on reset.
- Push while full with a same-cycle pop: the byte is still dropped; fullness is judged before the pop.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. Count is tracked separately: +1 on push only, −1 on pop only, unchanged when both occur.
- FSM states:
  - IDLE: if not empty and `uart_busy_i`=0, load `uart_dat_o` from the FIFO head, perform the pop, and go to ISSUE.
  - ISSUE: `uart_wr_o`=1. Stay until `uart_busy_i`=1 is sampled, then go to WAIT. `uart_wr_o` is deasserted on that transition.
  - WAIT: `uart_wr_o`=0. When `uart_busy_i`=0 is sampled, go to IDLE.
- Holding `uart_wr_o` until busy is seen is mandatory. The transmitter can miss a single-cycle request that coincides with its final bit tick; a re-asserted request reloads the same byte and is harmless.
- Push to an empty FIFO in the same cycle as an IDLE check: the byte is not visible until the next cycle; there is no bypass path.
- Reset mid-transfer: the FSM returns to IDLE and queued bytes are discarded. The transmitter shares `sys_rst_i`, so both sides realign.

## Timing
- Push at edge N: count and empty update at N+1; `uart_wr_o` rises at N+2 if the transmitter is idle.
- The transmitter asserts busy one cycle after accepting. `uart_wr_o` falls the cycle after busy is sampled high, so the request stays high for exactly 2 cycles in the normal case.
- Pop occurs on the IDLE→ISSUE edge. `txq_full_o` deasserts the next cycle.
- Back-to-back bytes: the next IDLE→ISSUE happens 1 cycle after busy falls. Throughput is bounded by the serial rate, not by the queue.

## Configuration
- `UART_TXQ_CRLF_EN` defined:
  - In IDLE, when the head byte is 0x0A and the CR-pending flag is 0: issue 0x0D without popping, and set the flag.
  - On the next IDLE pass: issue 0x0A, pop, and clear the flag.
  - All other bytes pass unchanged.
  - Reset clears the flag.
- Undefined: bytes pass verbatim, and the flag and comparison logic are absent.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding IDLE/ISSUE/WAIT.
  - Constants `UART_LF`=8'h0A and `UART_CR`=8'h0D.
- Sub-module `uart_txq_fifo`:
  - Holds the storage array, pointers, count, full/empty and overflow.
  - Exposes push, pop and head data.
- The top level holds the issue FSM and the CRLF logic.

## Test plan
- Reset, then push 0x55 into an idle system: `uart_wr_o` high 2 cycles later with `uart_dat_o`=0x55; serial line shows start bit, 0x55 LSB first, stop bit; `txq_idle_o` returns high.
- Push 0x01..0x10 back-to-back with DEPTH_LOG2=4: all 16 accepted and `txq_full_o`=1 after the 16th (one may pop early; re-fill to full). Push 0xFF while full: dropped, `txq_ovf_o`=1. Serial output is 0x01..0x10 in order.
- Simultaneous push and pop at count 5: count stays 5 and pointer wrap is exercised past index 15→0.
- Transmitter model that delays busy by 3 cycles: `uart_wr_o` held high with a stable byte until busy is seen; exactly one byte transmitted.
- Assert `sys_rst_i` mid-byte with 3 bytes queued: next cycle count=0, `uart_wr_o`=0, FSM IDLE; no further bytes sent.
- With `UART_TXQ_CRLF_EN`, push 0x41,0x0A,0x42: serial sequence is 0x41,0x0D,0x0A,0x42. Without the macro: 0x41,0x0A,0x42.
